// File: rtl/johnson_decoder.sv
// Johnson-code decoder with lock tracking.
// Decodes an N-bit twisted-ring code into a binary index, flags illegal
// patterns, and runs a HUNT/TRACK/LOCKED tracker over successive samples.
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset
//   sync_clr     synchronous clear of tracker state and error counter
//   code_valid   code_in is sampled this cycle
//   code_in      N-bit Johnson code
//   idx          decoded index of the last sample (IW bits)
//   idx_valid    one-cycle pulse when idx/legal were updated
//   legal        last sample matched a legal pattern
//   locked       tracker is in LOCKED
//   err_pulse    one-cycle error flag aligned with idx_valid
//   err_count    saturating 8-bit error count
module johnson_decoder #(
    parameter int unsigned N        = 4,
    parameter int unsigned LOCK_CNT = 4,
    localparam int unsigned IW      = $clog2(2 * N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          sync_clr,
    input  logic          code_valid,
    input  logic [N-1:0]  code_in,
    output logic [IW-1:0] idx,
    output logic          idx_valid,
    output logic          legal,
    output logic          locked,
    output logic          err_pulse,
    output logic [7:0]    err_count
);

    localparam int unsigned PW = IW + 1;
    localparam int unsigned CW = 4;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        TRACK  = 2'd1,
        LOCKED = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [IW-1:0]   prev_q, prev_d;
    logic [CW-1:0]   good_cnt_q, good_cnt_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic            idx_valid_q, idx_valid_d;
    logic            legal_q, legal_d;
    logic            locked_q, locked_d;
    logic            err_q, err_d;
    logic [7:0]      err_cnt_q, err_cnt_d;

    logic [PW-1:0]   pop_c;
    logic [IW-1:0]   idx_raw_c;
    logic            legal_raw_c;
    logic [IW-1:0]   prev_next_c;
    logic            good_c;
    logic            hold_c;

    // Legal pattern for index k: top k ones (k<=N), else top k-N zeros over ones.
    function automatic logic [N-1:0] pattern(input logic [IW-1:0] k);
        logic [N-1:0] p;
        int           ki;
        int           nn;
        ki = int'(k);
        nn = int'(N);
        p  = '0;
        for (int b = 0; b < nn; b++) begin
            if (ki <= nn) p[b] = (b >= nn - ki);
            else          p[b] = (b < 2 * nn - ki);
        end
        return p;
    endfunction

    // Decode: ones-filling half indexes by popcount, draining half by 2N - popcount.
    always_comb begin
        pop_c = '0;
        for (int b = 0; b < int'(N); b++) begin
            pop_c = pop_c + PW'(code_in[b]);
        end
        if (code_in[N-1] || (code_in == '0)) idx_raw_c = IW'(pop_c);
        else                                 idx_raw_c = IW'(PW'(2 * N) - pop_c);
        legal_raw_c = (code_in == pattern(idx_raw_c));
    end

    // Step classification against the last stored legal index (wraps 2N-1 -> 0).
    always_comb begin
        prev_next_c = (prev_q == IW'(2 * N - 1)) ? '0 : prev_q + IW'(1);
        good_c      = (idx_raw_c == prev_next_c);
        hold_c      = (idx_raw_c == prev_q);
    end

    // Next-state and output logic.
    always_comb begin
        state_d     = state_q;
        prev_d      = prev_q;
        good_cnt_d  = good_cnt_q;
        idx_d       = idx_q;
        legal_d     = legal_q;
        idx_valid_d = 1'b0;
        err_d       = 1'b0;
        err_cnt_d   = err_cnt_q;

        if (sync_clr) begin
            state_d    = HUNT;
            prev_d     = '0;
            good_cnt_d = '0;
            err_cnt_d  = '0;
        end else if (code_valid) begin
            idx_d       = idx_raw_c;
            legal_d     = legal_raw_c;
            idx_valid_d = 1'b1;
            if (!legal_raw_c) begin
                state_d = HUNT;
                err_d   = 1'b1;
            end else begin
                prev_d = idx_raw_c;
                unique case (state_q)
                    HUNT: begin
                        good_cnt_d = '0;
                        state_d    = TRACK;
                    end
                    TRACK: begin
                        if (good_c) begin
                            good_cnt_d = good_cnt_q + CW'(1);
                            if (good_cnt_q + CW'(1) == CW'(LOCK_CNT)) state_d = LOCKED;
                        end else if (!hold_c) begin
                            good_cnt_d = '0;
                            err_d      = 1'b1;
                        end
                    end
                    LOCKED: begin
                        if (!good_c && !hold_c) begin
                            state_d    = TRACK;
                            good_cnt_d = '0;
                            err_d      = 1'b1;
                        end
                    end
                    default: state_d = HUNT;
                endcase
            end
            if (err_d && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
        end

        locked_d = (state_d == LOCKED);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= HUNT;
            prev_q      <= '0;
            good_cnt_q  <= '0;
            idx_q       <= '0;
            idx_valid_q <= 1'b0;
            legal_q     <= 1'b0;
            locked_q    <= 1'b0;
            err_q       <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            prev_q      <= prev_d;
            good_cnt_q  <= good_cnt_d;
            idx_q       <= idx_d;
            idx_valid_q <= idx_valid_d;
            legal_q     <= legal_d;
            locked_q    <= locked_d;
            err_q       <= err_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign idx       = idx_q;
    assign idx_valid = idx_valid_q;
    assign legal     = legal_q;
    assign locked    = locked_q;
    assign err_pulse = err_q;
    assign err_count = err_cnt_q;

endmodule

// File: tb/tb_johnson_decoder.sv
// Testbench for johnson_decoder (N=4, LOCK_CNT=4): directed scenarios plus
// randomized traffic, checked every cycle against a behavioural model.
module tb_johnson_decoder;

    localparam int N    = 4;
    localparam int LCNT = 4;
    localparam int IW   = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          sync_clr;
    logic          code_valid;
    logic [N-1:0]  code_in;
    logic [IW-1:0] idx;
    logic          idx_valid;
    logic          legal;
    logic          locked;
    logic          err_pulse;
    logic [7:0]    err_count;

    int checks = 0;
    int errors = 0;

    johnson_decoder #(.N(N), .LOCK_CNT(LCNT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sync_clr  (sync_clr),
        .code_valid(code_valid),
        .code_in   (code_in),
        .idx       (idx),
        .idx_valid (idx_valid),
        .legal     (legal),
        .locked    (locked),
        .err_pulse (err_pulse),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    // Table pattern for index k, built arithmetically from the run-length rule.
    function automatic int pat(input int k);
        if (k <= N) return ((1 << k) - 1) << (N - k);
        return (1 << (2 * N - k)) - 1;
    endfunction

    // Behavioural model: expected outputs after each rising edge.
    int m_idx, m_iv, m_legal, m_lock, m_err, m_cnt;
    int have_prev, prev, run;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_idx = 0; m_iv = 0; m_legal = 0; m_lock = 0; m_err = 0; m_cnt = 0;
            have_prev = 0; prev = 0; run = 0;
        end else if (sync_clr) begin
            m_iv = 0; m_err = 0; m_cnt = 0; m_lock = 0;
            have_prev = 0; prev = 0; run = 0;
        end else if (code_valid) begin
            int c, k, pc;
            c       = int'(code_in);
            m_legal = 0;
            m_err   = 0;
            m_iv    = 1;
            k       = -1;
            for (int i = 0; i < 2 * N; i++) if (pat(i) == c) k = i;
            if (k >= 0) begin
                m_legal = 1;
                m_idx   = k;
            end else begin
                pc    = $countones(code_in);
                m_idx = (code_in[N-1] || c == 0) ? pc : 2 * N - pc;
            end
            if (!m_legal) begin
                m_err = 1; have_prev = 0; m_lock = 0; run = 0;
            end else if (!have_prev) begin
                have_prev = 1; prev = m_idx; run = 0;
            end else begin
                if (m_idx == (prev + 1) % (2 * N)) begin
                    if (!m_lock) begin
                        run++;
                        if (run == LCNT) m_lock = 1;
                    end
                end else if (m_idx != prev) begin
                    m_err = 1; m_lock = 0; run = 0;
                end
                prev = m_idx;
            end
            if (m_err && m_cnt < 255) m_cnt++;
        end else begin
            m_iv  = 0;
            m_err = 0;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        check("idx_valid", int'(idx_valid), m_iv);
        check("legal", int'(legal), m_legal);
        check("idx", int'(idx), m_idx);
        check("locked", int'(locked), m_lock);
        check("err_pulse", int'(err_pulse), m_err);
        check("err_count", int'(err_count), m_cnt);
    endtask

    task automatic step(input logic v, input int c, input logic clr);
        code_valid = v;
        code_in    = N'(c);
        sync_clr   = clr;
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_idx"}, int'(idx), 0);
        check({tag, "_iv"}, int'(idx_valid), 0);
        check({tag, "_legal"}, int'(legal), 0);
        check({tag, "_locked"}, int'(locked), 0);
        check({tag, "_err"}, int'(err_pulse), 0);
        check({tag, "_cnt"}, int'(err_count), 0);
    endtask

    initial begin
        int k;
        rst_n = 1'b0; sync_clr = 1'b0; code_valid = 1'b0; code_in = '0;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        rst_n = 1'b1;

        // Full sequence from reset: lock with idx=4, wrap 7 -> 0 clean.
        for (int i = 0; i < 2 * N; i++) begin
            step(1'b1, pat(i), 1'b0);
            if (i == 3) check("prelock", int'(locked), 0);
            if (i == 4) begin
                check("lock_idx4", int'(idx), 4);
                check("lock_rise", int'(locked), 1);
            end
        end
        step(1'b1, 0, 1'b0);
        check("wrap_idx", int'(idx), 0);
        check("wrap_locked", int'(locked), 1);
        check("wrap_err", int'(err_pulse), 0);
        check("wrap_cnt", int'(err_count), 0);

        // Illegal code while locked, then relock after 4 good steps.
        step(1'b1, 'b1010, 1'b0);
        check("ill_legal", int'(legal), 0);
        check("ill_idx", int'(idx), 2);
        check("ill_err", int'(err_pulse), 1);
        check("ill_cnt", int'(err_count), 1);
        check("ill_locked", int'(locked), 0);
        for (int i = 1; i <= 5; i++) begin
            step(1'b1, pat(i), 1'b0);
            if (i == 1) check("ill_err_once", int'(err_pulse), 0);
            if (i == 4) check("relock_pre", int'(locked), 0);
            if (i == 5) check("relock", int'(locked), 1);
        end

        // Holds and gaps while locked.
        for (int i = 6; i <= 10; i++) step(1'b1, pat(i % 8), 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, pat(3), 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 'b0101, 1'b0);
            check("gap_iv", int'(idx_valid), 0);
        end
        check("hold_locked", int'(locked), 1);
        check("hold_cnt", int'(err_count), 1);

        // Bad legal step from 1000 to 1111.
        for (int i = 4; i <= 9; i++) step(1'b1, pat(i % 8), 1'b0);
        step(1'b1, 'b1111, 1'b0);
        check("bad_err", int'(err_pulse), 1);
        check("bad_locked", int'(locked), 0);
        check("bad_cnt", int'(err_count), 2);
        step(1'b1, pat(5), 1'b0);
        check("bad_prev4", int'(err_pulse), 0);

        // Error burst saturates, then sync_clr wins over code_valid.
        for (int i = 0; i < 300; i++) step(1'b1, 'b1010, 1'b0);
        check("sat_cnt", int'(err_count), 255);
        step(1'b1, 'b1010, 1'b1);
        check("clr_cnt", int'(err_count), 0);
        check("clr_iv", int'(idx_valid), 0);
        check("clr_err", int'(err_pulse), 0);
        check("clr_locked", int'(locked), 0);

        // Randomized traffic.
        k = 0;
        for (int i = 0; i < 3000; i++) begin
            int r, c;
            r = int'($urandom_range(0, 99));
            if (r < 55)      begin k = (k + 1) % (2 * N); c = pat(k); end
            else if (r < 70) c = pat(k);
            else if (r < 82) begin k = int'($urandom_range(0, 2 * N - 1)); c = pat(k); end
            else             c = int'($urandom_range(0, (1 << N) - 1));
            step($urandom_range(0, 9) < 8, c, $urandom_range(0, 99) == 0);
        end

        // Asynchronous reset while locked, then relock needs LOCK_CNT+1 samples.
        step(1'b0, 0, 1'b1);
        for (int i = 0; i < 6; i++) step(1'b1, pat(i), 1'b0);
        check("ar_pre_locked", int'(locked), 1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("async");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 2; i <= 6; i++) begin
            step(1'b1, pat(i), 1'b0);
            if (i == 5) check("ar_relock_pre", int'(locked), 0);
            if (i == 6) check("ar_relock", int'(locked), 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/johnson_decoder.md
JOHNSON_DECODER -- requirements
Module: johnson_decoder

Interface
REQ-001 Parameter N, default 4: Johnson code width in bits, N >= 2; code space has 2N legal states.
REQ-002 Parameter LOCK_CNT, default 4: number of consecutive good steps needed to declare lock, 1..15.
REQ-003 Parameter IW = $clog2(2N) is derived, not overridable: width of the decoded index.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 sync_clr  input  1  synchronous clear of the FSM and the error counter.
REQ-007 code_valid  input  1  code_in is sampled this cycle.
REQ-008 code_in  input  N  Johnson-coded value from a twisted-ring counter.
REQ-009 idx  output  IW  decoded binary index of the last sampled code.
REQ-010 idx_valid  output  1  one-cycle pulse; idx/legal updated from a sample.
REQ-011 legal  output  1  last sampled code was one of the 2N legal patterns.
REQ-012 locked  output  1  FSM is in LOCKED.
REQ-013 err_pulse  output  1  one-cycle error indication.
REQ-014 err_count  output  8  saturating error count.

Function
REQ-015 The legal sequence for index k shall be as follows: for 0..N, the top k bits are 1 and the rest 0; for N+1..2N-1, the top k-N bits are 0 and the rest 1 (N=4: 0000,1000,1100,1110,1111,0111,0011,0001).
REQ-016 Decode: if code_in[N-1]=1 or code_in=0, idx_raw = popcount; otherwise idx_raw = 2N - popcount.
REQ-017 legal_raw shall be 1 iff code_in equals the table pattern for idx_raw; illegal codes still report idx_raw.
REQ-018 Latency: idx, legal and idx_valid shall be registered, 1 cycle after a code_valid=1 cycle.
REQ-019 idx_valid shall be low in every cycle that does not follow a code_valid=1 cycle; with code_valid=0, idx and legal shall hold.
REQ-020 The FSM shall have three states (HUNT, TRACK, LOCKED) and shall act only on code_valid=1 cycles.
REQ-021 Step classification (prev = last stored legal idx):
  - good = idx_raw == (prev+1) mod 2N; 2N-1 -> 0 is a good step.
  - hold = idx_raw == prev.
  - bad = any other legal value.
REQ-022 HUNT:
  - legal sample -> store prev, good_cnt=0, go to TRACK.
  - illegal sample -> stay in HUNT, err_pulse.
REQ-023 TRACK:
  - good -> good_cnt+1; LOCKED when good_cnt reaches LOCK_CNT.
  - hold -> no change.
  - bad -> good_cnt=0, prev=idx_raw, err_pulse.
  - illegal -> HUNT, err_pulse.
REQ-024 LOCKED:
  - good or hold -> stay.
  - bad -> TRACK, good_cnt=0, prev=idx_raw, err_pulse.
  - illegal -> HUNT, err_pulse.
REQ-025 prev shall update on every legal sample in TRACK or LOCKED; it shall never load an illegal code.
REQ-026 err_pulse shall be registered and aligned with idx_valid for the offending sample; err_count shall increment on the same edge and saturate at 255.
REQ-027 locked shall be a registered state decode and shall assert on the same edge as idx_valid for the LOCK_CNT-th good step.
REQ-028 sync_clr=1 shall force HUNT, clear good_cnt and err_count, drop idx_valid and err_pulse, and ignore code_valid that cycle; sync_clr takes priority over code_valid.

Reset
REQ-029 While rst_n=0, all outputs shall be held at reset values regardless of clk: idx=0, idx_valid=0, legal=0, locked=0, err_pulse=0, err_count=0; FSM=HUNT, prev=0, good_cnt=0.
REQ-030 Reset asserted mid-sequence shall drop locked immediately (asynchronously); after release, at least LOCK_CNT+1 legal samples are needed to relock.

Verification
REQ-031 Reset, then N=4 full sequence 0000,1000,...,0001,0000 with code_valid=1 every cycle -> idx 0,1,...,7,0; legal=1 throughout; locked rises with idx=4; err_count=0.
REQ-032 Locked and at idx=7 (0001), next code 0000 -> idx=0, no err_pulse, locked stays 1 (wrap).
REQ-033 Locked, inject 1010 -> legal=0, err_pulse for one cycle, err_count+1, locked=0, FSM in HUNT; 4 further good steps from the next legal code -> relock.
REQ-034 Locked at 1100, then 1110,1110,1110 (holds), then gaps with code_valid=0 -> no errors, locked=1, idx_valid pulses only on valid cycles.
REQ-035 Locked at 1000, inject legal 1111 (bad step) -> err_pulse, FSM in TRACK with prev=4; a 300-error burst -> err_count=255 (saturates); sync_clr -> err_count=0, locked=0.
REQ-036 rst_n driven low between clock edges while locked -> all outputs 0 before the next rising edge.
